// File: rtl/print_tx.sv
// Formats a 32-bit word as one raw byte or eight uppercase hex chars and shifts it out as 8N1 UART.
// Start bit follows a request by 2 cycles and the next char follows a stop bit by 3; req_tx is ignored until the print completes.
module print_tx #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dout_tx,
  input  logic        type_tx,
  input  logic        req_tx,
  output logic        ack_tx,
  output logic        txd
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state, state_nxt;
  logic [31:0] word_q;
  logic        type_q;
  logic [2:0]  idx;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;
  logic        last_char;
  logic [2:0]  nib_sel;
  logic [3:0]  nib;
  logic [7:0]  char_sel;

  logic        busy;
  logic [9:0]  shreg;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // idx 0 picks the most significant nibble
  assign nib_sel   = 3'd7 - idx;
  assign nib       = word_q[{nib_sel, 2'b00} +: 4];
  assign char_sel  = type_q ? hex_ascii(nib) : word_q[7:0];
  assign last_char = !type_q || (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vld_tx    = 1'b0;
    ack_tx    = 1'b0;
    case (state)
      IDLE: if (req_tx) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        vld_tx = 1'b1;
        if (rdy_tx) state_nxt = WAIT;
      end
      WAIT: if (rdy_tx) state_nxt = last_char ? DONE : LOAD;
      DONE: begin
        ack_tx    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      word_q <= '0;
      type_q <= 1'b0;
      idx    <= '0;
      d_tx   <= '0;
    end else begin
      if (state == IDLE && req_tx) begin
        word_q <= dout_tx;
        type_q <= type_tx;
        idx    <= '0;
      end
      if (state == LOAD) d_tx <= char_sel;
      if (state == WAIT && rdy_tx && !last_char) idx <= idx + 3'd1;
    end
  end

  // Transmitter: shreg holds {stop, data, start} and shifts out LSB first
  assign rdy_tx = !busy;
  assign txd    = busy ? shreg[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rstn) begin
      busy     <= 1'b0;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!busy) begin
      if (vld_tx) begin
        busy     <= 1'b1;
        shreg    <= {1'b1, d_tx, 1'b0};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      shreg    <= {1'b1, shreg[9:1]};
      if (bit_cnt == 4'd9) busy <= 1'b0;
      else                 bit_cnt <= bit_cnt + 4'd1;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_print_tx.sv
// Bench for print_tx at BAUD_DIV=4: txd is decoded at bit centres and each byte is
// popped against a queue of expected chars filled when a request is driven.
module tb_print_tx;

  logic        clk;
  logic        rstn;
  logic [31:0] dout_tx;
  logic        type_tx;
  logic        req_tx;
  logic        ack_tx;
  logic        txd;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int byte_cnt = 0;
  int req_cyc  = 0;
  int stop_end = 0;
  bit first_pending = 1'b0;
  bit gap_armed     = 1'b0;
  logic [7:0] exp_q[$];
  string hex_digits = "0123456789ABCDEF";

  print_tx #(.BAUD_DIV(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .dout_tx (dout_tx),
    .type_tx (type_tx),
    .req_tx  (req_tx),
    .ack_tx  (ack_tx),
    .txd     (txd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic t);
    logic [31:0] tmp;
    if (!t) begin
      exp_q.push_back(w[7:0]);
    end else begin
      tmp = w;
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(hex_digits[tmp[31:28]]);
        tmp = tmp << 4;
      end
    end
    first_pending = 1'b1;
  endtask

  task automatic do_req(input logic [31:0] w, input logic t, input bit expect_print);
    @(posedge clk); #1;
    dout_tx = w;
    type_tx = t;
    req_tx  = 1'b1;
    req_cyc = cyc;
    if (expect_print) push_exp(w, t);
    @(posedge clk); #1;
    req_tx  = 1'b0;
    dout_tx = $urandom;
    type_tx = ~t;
  endtask

  task automatic wait_ack(input string tag);
    int k;
    k = 0;
    while (ack_tx !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ack"}, 32'(ack_tx), 32'd1);
  endtask

  task automatic run_print(input string tag, input logic [31:0] w, input logic t);
    int n0;
    n0 = ack_cnt;
    do_req(w, t, 1'b1);
    wait_ack(tag);
    repeat (20) @(negedge clk);
    check({tag, "_acks"}, ack_cnt - n0, 32'd1);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  // txd decoder: frame begins at the first low sample, bit b centre at cycle 4b+2
  initial begin : txd_mon
    logic [9:0] bits;
    logic       first;
    bit         aborted;
    bit         steady;
    int         s;
    forever begin
      @(negedge clk);
      if (rstn === 1'b0 && txd === 1'b0) begin
        s = cyc;
        aborted = 1'b0;
        steady  = 1'b1;
        bits    = '0;
        first   = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < 4; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rstn !== 1'b0) aborted = 1'b1;
            if (c == 0) first = txd;
            else if (txd !== first) steady = 1'b0;
            if (c == 2) bits[b] = txd;
          end
        end
        if (!aborted) begin
          if (first_pending) begin
            check("req_to_start", 32'(s - (req_cyc + 1) <= 3), 32'd1);
            first_pending = 1'b0;
          end else if (gap_armed) begin
            check("char_gap", 32'(s - stop_end <= 3), 32'd1);
          end
          stop_end = s + 40;
          check("bit_len", 32'(steady), 32'd1);
          check("start_stop", 32'({bits[9], bits[0]}), 32'h2);
          check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("char", 32'(bits[8:1]), 32'(exp_q.pop_front()));
          byte_cnt++;
          gap_armed = (exp_q.size() != 0);
        end
      end
    end
  end

  initial begin : ack_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_tx === 1'b1) begin
        ack_cnt++;
        check("ack_width", 32'(prev), 32'd0);
        check("ack_after_stop", 32'((cyc >= stop_end) && (cyc - stop_end <= 3)), 32'd1);
        check("ack_all_sent", exp_q.size(), 32'd0);
      end
      prev = ack_tx;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    int base;
    int k;
    rstn    = 1'b1;
    req_tx  = 1'b0;
    dout_tx = '0;
    type_tx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ack", 32'(ack_tx), 32'd0);
    rstn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_txd", 32'(txd), 32'd1);

    run_print("hex31", 32'h0000_0031, 1'b1);
    run_print("raw31", 32'h0000_0031, 1'b0);
    run_print("deadbeef", 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 3; i++) run_print("rand", $urandom, 1'($urandom_range(0, 1)));

    // request held high from mid-print through the ack cycle must be ignored
    n0 = ack_cnt;
    do_req(32'h0BAD_F00D, 1'b1, 1'b1);
    repeat (60) @(negedge clk);
    @(posedge clk); #1;
    dout_tx = 32'h1111_2222;
    type_tx = 1'b0;
    req_tx  = 1'b1;
    wait_ack("busy_req");
    @(posedge clk); #1;
    req_tx = 1'b0;
    repeat (150) @(negedge clk);
    check("busy_req_acks", ack_cnt - n0, 32'd1);
    check("busy_req_drained", exp_q.size(), 32'd0);
    run_print("after_busy", 32'h1111_2222, 1'b0);

    // reset during the third character
    n0   = ack_cnt;
    base = byte_cnt;
    do_req(32'hDEAD_BEEF, 1'b1, 1'b1);
    k = 0;
    while (byte_cnt < base + 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (txd !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("third_char_started", 32'(txd), 32'd0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_ack", 32'(ack_tx), 32'd0);
    exp_q.delete();
    first_pending = 1'b0;
    gap_armed     = 1'b0;
    rstn = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_no_ack", ack_cnt - n0, 32'd0);
    check("abort_bytes", byte_cnt - base, 32'd2);
    run_print("after_reset", 32'h1234_5678, 1'b1);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/print_tx.md
PRINT_TX -- requirements
Module: print_tx

Parameters
REQ-001 BAUD_DIV, default 868, clock cycles per UART bit; legal range 2..65535.

Interface
REQ-002 clk  input  1  system clock; all logic SHALL be rising-edge triggered on clk.
REQ-003 rstn  input  1  synchronous reset, active-high (rstn=1 resets on the next rising edge).
REQ-004 dout_tx  input  32  data word to print.
REQ-005 type_tx  input  1  print format: 0 = one raw byte dout_tx[7:0]; 1 = 32-bit word as 8 hex ASCII chars.
REQ-006 req_tx  input  1  print request, sampled every cycle.
REQ-007 ack_tx  output  1  one-cycle completion pulse.
REQ-008 txd  output  1  UART serial line, 8N1, idle high.

Function
REQ-009 Internal split: formatter (PRINT) drives byte d_tx[7:0] with vld_tx to transmitter (TX), which returns rdy_tx; a byte transfers on a cycle with vld_tx=1 and rdy_tx=1.
REQ-010 Formatter states: IDLE, LOAD, SEND, WAIT, DONE.
REQ-011 IDLE: on req_tx=1, latch dout_tx and type_tx, clear char index, go LOAD; otherwise remain in IDLE.
REQ-012 req_tx while not IDLE SHALL be ignored; the latched word is not altered by later dout_tx/type_tx changes.
REQ-013 Char count: 1 when type=0, 8 when type=1.
REQ-014 Hex encoding: nibble 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase); most significant nibble (bits 31:28) first.
REQ-015 LOAD: select char[index] onto d_tx, go SEND.
REQ-016 SEND: hold vld_tx=1 until rdy_tx=1, then go WAIT.
REQ-017 WAIT: once the transmitter is ready again (stop bit complete), increment index; go LOAD if chars remain, else DONE.
REQ-018 DONE: ack_tx=1 for exactly one cycle, then IDLE; ack_tx=0 in all other states.
REQ-019 Transmitter: rdy_tx=1 only when idle; on acceptance, latch the byte and send start bit 0, 8 data bits LSB first, stop bit 1.
REQ-020 Each bit SHALL last exactly BAUD_DIV cycles (frame = 10*BAUD_DIV cycles); rdy_tx returns 1 on the cycle after the stop bit ends.
REQ-021 Latency: first start bit begins at most 3 cycles after req_tx is sampled; gap between a stop bit and the next start bit is at most 3 cycles.
REQ-022 ack_tx SHALL rise no earlier than the end of the last stop bit and at most 3 cycles after it.
REQ-023 A req_tx sampled in the same cycle as ack_tx=1 SHALL be ignored; a new request is accepted only once back in IDLE.

Reset
REQ-024 rstn=1 on a rising edge forces: formatter IDLE, transmitter idle, txd=1, ack_tx=0, vld_tx=0, rdy_tx=1, index=0.
REQ-025 Reset mid-frame aborts the print: txd=1 on the following cycle, no ack_tx, and no further chars are sent.

Verification
REQ-026 Bench SHALL use BAUD_DIV=4 and decode txd by sampling at bit centres.
REQ-027 dout_tx=0x00000031, type_tx=1, req_tx pulse -> bytes 30 30 30 30 30 30 33 31 ("00000031") on txd, then a single ack_tx pulse.
REQ-028 dout_tx=0x00000031, type_tx=0, req_tx pulse -> single byte 0x31 framed 0,1,0,0,0,1,1,0,0,1 (each bit 4 cycles), then ack_tx.
REQ-029 dout_tx=0xDEADBEEF, type_tx=1 -> "DEADBEEF" (44 45 41 44 42 45 45 46); no lowercase characters.
REQ-030 Second req_tx mid-print with a changed dout_tx -> output unchanged, exactly one ack_tx; a later req_tx in IDLE prints the new word.
REQ-031 Reset asserted during the 3rd character -> txd=1 next cycle, no ack_tx; a new request afterwards prints a complete string.
